// File: rtl/riscv_ai_vec_unit.sv
// riscv_ai_vec_unit: packed-SIMD neural-network helper on the custom-0 opcode.
// Commands enter a small in-order queue. A three-state FSM (IDLE/EXEC/RESP)
// runs them one at a time: ReLU, max, saturating add, dot-product MAC and
// accumulator read-and-clear, on INT8/16/32 lanes. Each result is returned
// with its rd tag and flags over a valid/ready channel.
// Optional feature macro: AI_VEC_SAT_STATS_EN. When defined, it adds a 16-bit
// saturating count of clamp events on ai_sat_count. When undefined, the output
// is tied to zero.
module riscv_ai_vec_unit #(
  parameter int XLEN   = 64,
  parameter int QDEPTH = 4,
  parameter int ACC_W  = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [6:0]      ai_opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ai_flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] ai_result,
  output logic [2:0]      ai_flags,
  output logic            ai_busy,
  output logic [15:0]     ai_sat_count
);

  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = PW + 1;
  localparam int LCW   = $clog2(XLEN / 8);
  localparam int NCW   = $clog2(XLEN / 8 + 1);
  localparam int SUM_W = 66 + $clog2(XLEN);  // holds any exact lane-product sum
  localparam int TOT_W = SUM_W + 1;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_VRELU    = 7'b0000100;
  localparam logic [6:0] F7_VMAX     = 7'b0001000;
  localparam logic [6:0] F7_VADDS    = 7'b0100000;
  localparam logic [6:0] F7_VDOT     = 7'b0100001;
  localparam logic [6:0] F7_ACCRD    = 7'b0100010;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  typedef struct packed {
    logic            opc_ok;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } cmd_t;

  cmd_t                     q_mem [QDEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            q_cnt;
  logic                     push, pop;

  state_t                   state, state_nxt;
  cmd_t                     cur;
  logic [LCW-1:0]           lane_cnt, lane_last;
  logic signed [SUM_W-1:0]  dot_sum, dot_next;
  logic signed [ACC_W-1:0]  acc, acc_new, acc_d;
  logic                     acc_we;

  logic                     type_ok, func_ok, op_valid, is_dot, exec_done;
  logic [LCW+4:0]           sh;
  logic [31:0]              a_sh, b_sh;
  logic signed [31:0]       la, lb;
  logic signed [63:0]       prod;
  logic signed [TOT_W-1:0]  dot_total, acc_max, acc_min;
  logic                     dot_sat;

  logic [XLEN-1:0]          simd8, simd16, simd32, simd_res;
  logic [NCW-1:0]           n8, n16, n32, simd_clamps;
  logic [32:0]              t;
  logic [XLEN-1:0]          wb_result;
  logic [2:0]               wb_flags;

  // Sign-extend one W-bit lane pair and apply an element-wise operation.
  // Bit 32 of the return value reports that a saturating add clamped.
  function automatic logic [32:0] lane_calc(input logic [31:0] a_raw,
                                            input logic [31:0] b_raw,
                                            input int          w,
                                            input logic [6:0]  f7);
    logic signed [33:0] a, b, s, hi, lo;
    logic signed [31:0] r;
    logic               clamp;
    a     = 34'($signed(a_raw << (32 - w))) >>> (32 - w);
    b     = 34'($signed(b_raw << (32 - w))) >>> (32 - w);
    hi    = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo    = -(34'sd1 <<< (w - 1));
    s     = a + b;
    clamp = 1'b0;
    r     = '0;
    case (f7)
      F7_VRELU: r = (a < 0) ? 32'sd0 : 32'(a);
      F7_VMAX:  r = (a > b) ? 32'(a) : 32'(b);
      F7_VADDS: begin
        if (s > hi) begin
          r = 32'(hi); clamp = 1'b1;
        end else if (s < lo) begin
          r = 32'(lo); clamp = 1'b1;
        end else begin
          r = 32'(s);
        end
      end
      default:  r = '0;
    endcase
    return {clamp, r};
  endfunction

  assign push        = issue_valid && issue_ready && !ai_flush;
  assign pop         = !ai_flush && (q_cnt != '0) &&
                       ((state == S_IDLE) || ((state == S_RESP) && res_ready));
  assign issue_ready = (q_cnt != CW'(QDEPTH));
  assign res_valid   = (state == S_RESP);
  assign ai_busy     = (q_cnt != '0) || (state != S_IDLE);

  // Command storage: data only, no reset.
  // NOTE: queue entries are never read before being written (count guards the head), so the storage array needs no reset and stays a plain RAM.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{opc_ok: (ai_opcode == OPC_CUSTOM0), f3: funct3,
                                 f7: funct7, rd: rd, a: rs1_data, b: rs2_data};
  end

  // Queue pointers and occupancy; flush empties the queue.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (ai_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: fetch, execute (multi-cycle for VDOT), hold response.
  // NOTE: every combinational output gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    if (ai_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (q_cnt != '0) state_nxt = S_EXEC;
        S_EXEC:  if (exec_done)   state_nxt = S_RESP;
        S_RESP:  if (res_ready)   state_nxt = (q_cnt != '0) ? S_EXEC : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Decode of the current command and the per-cycle VDOT lane product.
  always_comb begin
    type_ok  = (cur.f3 <= 3'd2);
    func_ok  = cur.opc_ok && (cur.f7 inside {F7_VRELU, F7_VMAX, F7_VADDS, F7_VDOT, F7_ACCRD});
    op_valid = type_ok && func_ok;
    is_dot   = op_valid && (cur.f7 == F7_VDOT);
    case (cur.f3)
      3'd0:    begin lane_last = LCW'(XLEN / 8 - 1);  sh = {lane_cnt, 3'b000};           end
      3'd1:    begin lane_last = LCW'(XLEN / 16 - 1); sh = {lane_cnt[LCW-2:0], 4'b0000}; end
      default: begin lane_last = LCW'(XLEN / 32 - 1); sh = {lane_cnt[LCW-3:0], 5'b00000}; end
    endcase
    exec_done = (state == S_EXEC) && (!is_dot || (lane_cnt == lane_last));
    a_sh = 32'(cur.a >> sh);
    b_sh = 32'(cur.b >> sh);
    case (cur.f3)
      3'd0:    begin la = 32'(signed'(a_sh[7:0]));  lb = 32'(signed'(b_sh[7:0]));  end
      3'd1:    begin la = 32'(signed'(a_sh[15:0])); lb = 32'(signed'(b_sh[15:0])); end
      default: begin la = signed'(a_sh);            lb = signed'(b_sh);            end
    endcase
    prod      = 64'(la) * 64'(lb);
    dot_next  = dot_sum + SUM_W'(prod);
    dot_total = TOT_W'(acc) + TOT_W'(dot_next);
    acc_max   = {{(TOT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    acc_min   = {{(TOT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    dot_sat   = (dot_total > acc_max) || (dot_total < acc_min);
    if (dot_total > acc_max)      acc_new = acc_max[ACC_W-1:0];
    else if (dot_total < acc_min) acc_new = acc_min[ACC_W-1:0];
    else                          acc_new = dot_total[ACC_W-1:0];
  end

  // Element-wise SIMD results for all three lane widths, then width select.
  always_comb begin
    simd8 = '0; simd16 = '0; simd32 = '0;
    n8 = '0; n16 = '0; n32 = '0;
    t = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      t = lane_calc({24'b0, cur.a[i*8 +: 8]}, {24'b0, cur.b[i*8 +: 8]}, 8, cur.f7);
      simd8[i*8 +: 8] = t[7:0];
      n8 = n8 + NCW'(t[32]);
    end
    for (int i = 0; i < XLEN / 16; i++) begin
      t = lane_calc({16'b0, cur.a[i*16 +: 16]}, {16'b0, cur.b[i*16 +: 16]}, 16, cur.f7);
      simd16[i*16 +: 16] = t[15:0];
      n16 = n16 + NCW'(t[32]);
    end
    for (int i = 0; i < XLEN / 32; i++) begin
      t = lane_calc(cur.a[i*32 +: 32], cur.b[i*32 +: 32], 32, cur.f7);
      simd32[i*32 +: 32] = t[31:0];
      n32 = n32 + NCW'(t[32]);
    end
    case (cur.f3)
      3'd0:    begin simd_res = simd8;  simd_clamps = n8;  end
      3'd1:    begin simd_res = simd16; simd_clamps = n16; end
      default: begin simd_res = simd32; simd_clamps = n32; end
    endcase
  end

  // Result, flags and accumulator update for the finishing operation.
  always_comb begin
    wb_result = '0;
    wb_flags  = '0;
    acc_we    = 1'b0;
    acc_d     = acc;
    if (!op_valid) begin
      wb_flags = {!type_ok, !func_ok, 1'b0};
    end else begin
      case (cur.f7)
        F7_VDOT: begin
          wb_result = XLEN'(acc_new);
          wb_flags  = {2'b00, dot_sat};
          acc_we    = 1'b1;
          acc_d     = acc_new;
        end
        F7_ACCRD: begin
          wb_result = XLEN'(acc);
          acc_we    = 1'b1;
          acc_d     = '0;
        end
        F7_VADDS: begin
          wb_result = simd_res;
          wb_flags  = {2'b00, (simd_clamps != '0)};
        end
        default: wb_result = simd_res;
      endcase
    end
  end

  // Operand capture, VDOT lane stepping, result and accumulator commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      lane_cnt  <= '0;
      dot_sum   <= '0;
      acc       <= '0;
      res_rd    <= '0;
      ai_result <= '0;
      ai_flags  <= '0;
    end else if (ai_flush) begin
      lane_cnt <= '0;
      dot_sum  <= '0;
    end else if (pop) begin
      cur      <= q_mem[rd_ptr];
      lane_cnt <= '0;
      dot_sum  <= '0;
    end else if (state == S_EXEC) begin
      if (!exec_done) begin
        dot_sum  <= dot_next;
        lane_cnt <= lane_cnt + LCW'(1);
      end else begin
        res_rd    <= cur.rd;
        ai_result <= wb_result;
        ai_flags  <= wb_flags;
        if (acc_we) acc <= acc_d;
      end
    end
  end

`ifdef AI_VEC_SAT_STATS_EN
  logic [15:0]    sat_cnt;
  logic [NCW-1:0] sat_inc;
  logic [16:0]    sat_sum;

  assign sat_inc = (op_valid && (cur.f7 == F7_VADDS)) ? simd_clamps :
                   (is_dot ? NCW'(dot_sat) : '0);
  assign sat_sum = 17'(sat_cnt) + 17'(sat_inc);

  // Saturating count of clamped lanes and saturating dot products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       sat_cnt <= '0;
    else if (exec_done && !ai_flush)  sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  assign ai_sat_count = sat_cnt;
`else
  assign ai_sat_count = 16'h0;
`endif

endmodule

// File: tb/tb_riscv_ai_vec_unit.sv
// Testbench for riscv_ai_vec_unit (XLEN=64, QDEPTH=4, ACC_W=48).
// Expected results come from a lane-by-lane arithmetic model and are queued
// when a command is accepted. A monitor pops and compares on each result
// handshake.
module tb_riscv_ai_vec_unit;
  localparam int XLEN = 64;
  localparam logic [6:0] OPC   = 7'b0001011;
  localparam logic [6:0] VRELU = 7'b0000100;
  localparam logic [6:0] VMAX  = 7'b0001000;
  localparam logic [6:0] VADDS = 7'b0100000;
  localparam logic [6:0] VDOT  = 7'b0100001;
  localparam logic [6:0] ACCRD = 7'b0100010;

  logic            clk, rst_n;
  logic            issue_valid, issue_ready;
  logic [6:0]      ai_opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            ai_flush, res_valid, res_ready;
  logic [4:0]      res_rd;
  logic [XLEN-1:0] ai_result;
  logic [2:0]      ai_flags;
  logic            ai_busy;
  logic [15:0]     ai_sat_count;

  riscv_ai_vec_unit #(.XLEN(64), .QDEPTH(4), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ai_opcode(ai_opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ai_flush(ai_flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
    .ai_result(ai_result), .ai_flags(ai_flags), .ai_busy(ai_busy),
    .ai_sat_count(ai_sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [47:0] m_acc;
  int                 m_sat;
  int                 checks   = 0;
  int                 failures = 0;
  int                 accepted = 0;
  bit                 rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint lane_val(input logic [63:0] v, input int i, input int w);
    longint x;
    x = longint'((v >> (i * w)) & ((64'd1 << w) - 64'd1));
    if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
    return x;
  endfunction

  // Reference behaviour: plain integer arithmetic per lane, acc kept as a number.
  task automatic ref_model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] data, output logic [2:0] flags);
    bit                  ok_op, ok_t;
    int                  w, lanes, clamps;
    longint              x, y, s, hi, lo;
    logic signed [127:0] tot;
    data   = '0;
    flags  = '0;
    clamps = 0;
    ok_op  = (opc == OPC) && (f7 == VRELU || f7 == VMAX || f7 == VADDS || f7 == VDOT || f7 == ACCRD);
    ok_t   = (f3 <= 3'd2);
    if (!ok_op || !ok_t) begin
      flags = {!ok_t, !ok_op, 1'b0};
      return;
    end
    w     = 8 << f3;
    lanes = 64 / w;
    hi    = (longint'(1) << (w - 1)) - 1;
    lo    = -(longint'(1) << (w - 1));
    if (f7 == ACCRD) begin
      data  = 64'(m_acc);
      m_acc = '0;
    end else if (f7 == VDOT) begin
      tot = 128'(m_acc);
      for (int i = 0; i < lanes; i++) tot = tot + lane_val(a, i, w) * lane_val(b, i, w);
      if (tot > 128'sh7FFF_FFFF_FFFF) begin
        tot = 128'sh7FFF_FFFF_FFFF; flags[0] = 1'b1;
      end else if (tot < -128'sh8000_0000_0000) begin
        tot = -128'sh8000_0000_0000; flags[0] = 1'b1;
      end
      m_acc = tot[47:0];
      data  = 64'(m_acc);
      if (flags[0]) clamps = 1;
    end else begin
      for (int i = 0; i < lanes; i++) begin
        x = lane_val(a, i, w);
        y = lane_val(b, i, w);
        if (f7 == VRELU)     s = (x < 0) ? 0 : x;
        else if (f7 == VMAX) s = (x > y) ? x : y;
        else begin
          s = x + y;
          if (s > hi)      begin s = hi; clamps++; end
          else if (s < lo) begin s = lo; clamps++; end
        end
        data = data | ((64'(s) & ((64'd1 << w) - 64'd1)) << (i * w));
      end
      if (clamps != 0) flags[0] = 1'b1;
    end
    m_sat = (m_sat + clamps > 65535) ? 65535 : m_sat + clamps;
  endtask

  // Offer one command; leaves issue_valid asserted at posedge+1 after the handshake.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd_t, input logic [63:0] a, input logic [63:0] b,
                       input bit track);
    bit   got;
    exp_t e;
    issue_valid = 1'b1; ai_opcode = opc; funct3 = f3; funct7 = f7;
    rd = rd_t; rs1_data = a; rs2_data = b;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      got = issue_ready;
    end
    if (!got) begin
      check("issue_timeout", 64'd0, 64'd1);
      issue_valid = 1'b0;
      return;
    end
    if (track) begin
      e.rd = rd_t;
      ref_model(opc, f3, f7, a, b, e.data, e.flags);
      exp_q.push_back(e);
    end
    accepted++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !ai_busy;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Issue from idle and measure cycles from handshake to res_valid.
  task automatic issue_lat(input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd_t,
                           input logic [63:0] a, input logic [63:0] b, input int exp_lat,
                           input string name);
    int lat;
    bit seen;
    issue(OPC, f3, f7, rd_t, a, b, 1'b1);
    issue_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = res_valid;
    end
    check(name, 64'(lat), 64'(exp_lat));
    drain();
  endtask

  task automatic check_sat(input string name);
`ifdef AI_VEC_SAT_STATS_EN
    check(name, 64'(ai_sat_count), 64'(m_sat));
`else
    check(name, 64'(ai_sat_count), 64'd0);
`endif
  endtask

  // Scoreboard monitor: compare each accepted result against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got rd=%0d data=%h required no result", res_rd, ai_result);
        end else begin
          e = exp_q.pop_front();
          check("res_rd", 64'(res_rd), 64'(e.rd));
          check("res_data", ai_result, e.data);
          check("res_flags", 64'(ai_flags), 64'(e.flags));
        end
      end
    end
  end

  // Random backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] f7_tab [6];
    int         flushed_res;
    f7_tab = '{VRELU, VMAX, VADDS, VDOT, ACCRD, 7'h7F};
    rst_n = 1'b0; issue_valid = 1'b0; ai_opcode = OPC; funct3 = '0; funct7 = '0;
    rd = '0; rs1_data = '0; rs2_data = '0; ai_flush = 1'b0; res_ready = 1'b1;
    m_acc = '0; m_sat = 0;
    #22;
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_rd", 64'(res_rd), 64'd0);
    check("rst_result", ai_result, 64'd0);
    check("rst_flags", 64'(ai_flags), 64'd0);
    check("rst_busy", 64'(ai_busy), 64'd0);
    check("rst_sat", 64'(ai_sat_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: INT8 ReLU, latency 3.
    issue_lat(3'd0, VRELU, 5'd1, 64'h807F01FF0010F005, 64'h0, 3, "t1_latency");
    // T2: INT16 saturating add, all four lanes clamp.
    issue(OPC, 3'd1, VADDS, 5'd2, {4{16'h7FF0}}, {4{16'h0020}}, 1'b1);
    issue_valid = 1'b0;
    drain();
    check_sat("t2_sat_count");
    // T3: INT32 dot product accumulate, read-and-clear, restart.
    issue_lat(3'd2, VDOT, 5'd3, {32'd2, 32'd3}, {32'd4, 32'd5}, 4, "t3_latency_a");
    issue_lat(3'd2, VDOT, 5'd4, {32'd2, 32'd3}, {32'd4, 32'd5}, 4, "t3_latency_b");
    issue(OPC, 3'd2, ACCRD, 5'd5, 64'h0, 64'h0, 1'b1);
    issue(OPC, 3'd2, VDOT, 5'd6, {32'd2, 32'd3}, {32'd4, 32'd5}, 1'b1);
    issue_valid = 1'b0;
    drain();

    // T6: abort an INT8 VDOT on its third EXEC cycle; issue in flush cycle is dropped.
    issue(OPC, 3'd0, VDOT, 5'd7, 64'h7F7F7F7F7F7F7F7F, 64'h0102030405060708, 1'b0);
    issue_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    ai_flush = 1'b1;
    issue_valid = 1'b1; funct7 = ACCRD; rd = 5'd8;
    @(posedge clk);
    #1;
    ai_flush = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    check("t6_res_valid_after_flush", 64'(res_valid), 64'd0);
    check("t6_busy_after_flush", 64'(ai_busy), 64'd0);
    flushed_res = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (res_valid) flushed_res++;
    end
    check("t6_no_result", 64'(flushed_res), 64'd0);
    @(posedge clk);
    #1;
    issue(OPC, 3'd0, ACCRD, 5'd9, 64'h0, 64'h0, 1'b1);
    issue_valid = 1'b0;
    drain();

    // T4: backpressure fills the queue, then releases in order.
    res_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(OPC, 3'd0, VRELU, 5'(10 + i), {$urandom, $urandom}, 64'h0, 1'b1);
        issue_valid = 1'b0;
      end
      begin
        repeat (14) @(negedge clk);
        check("t4_accepted", 64'(accepted), 64'd5);
        check("t4_issue_ready", 64'(issue_ready), 64'd0);
        check("t4_busy", 64'(ai_busy), 64'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    drain();
    check("t4_total_accepted", 64'(accepted), 64'd6);

    // T5: invalid funct7, funct3 and opcode.
    issue(OPC, 3'd0, 7'h7F, 5'd20, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    issue(OPC, 3'b100, VRELU, 5'd21, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    issue(7'h33, 3'd0, VRELU, 5'd22, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    issue_valid = 1'b0;
    drain();

    // Randomized mix with random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [6:0] opc_r;
      logic [2:0] f3_r;
      opc_r = ($urandom_range(0, 15) == 0) ? 7'h33 : OPC;
      f3_r  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      issue(opc_r, f3_r, f7_tab[$urandom_range(0, 5)], 5'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        issue_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    issue_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();
    check_sat("rand_sat_count");

    // Asynchronous reset in the middle of a VDOT.
    issue(OPC, 3'd0, VDOT, 5'd1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    issue_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(ai_busy), 64'd0);
    check("arst_res_valid", 64'(res_valid), 64'd0);
    check("arst_issue_ready", 64'(issue_ready), 64'd1);
    check("arst_sat", 64'(ai_sat_count), 64'd0);
    m_acc = '0;
    m_sat = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OPC, 3'd0, ACCRD, 5'd31, 64'h0, 64'h0, 1'b1);
    issue_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
